// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller with frame-aligned value updates.
// Optional leading-zero blanking is built when SEG_LZB_EN is defined.
module seg_scan_ctrl #(
    parameter int unsigned TICK_DIV  = 10000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  nibble,
    output logic        blank,
    output logic [3:0]  digit_sel,
    output logic        frame_done
);

    localparam int unsigned CMAX = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ACTIVE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    d, d_nx;
    logic [15:0]   disp, disp_nx;
    logic [15:0]   pend, pend_nx;
    logic          pend_v, pend_v_nx;
    logic          commit;

    logic [3:0]    nibble_nx;
    logic          blank_nx;
    logic [3:0]    digit_sel_nx;
    logic          frame_done_nx;
    logic [3:0]    nib_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            d      <= '0;
            disp   <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            d      <= d_nx;
            disp   <= disp_nx;
            pend   <= pend_nx;
            pend_v <= pend_v_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        d_nx     = d;
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            d_nx     = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    d_nx     = '0;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nx = ACTIVE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                ACTIVE: begin
                    if (cnt == TICK_LAST) begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                        d_nx     = d + 2'd1;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    d_nx     = '0;
                end
            endcase
        end
    end

    // Commit happens only when entering the digit0 blank gap; load_ready mirrors !pend_v,
    // so an accept can never coincide with a commit of the same buffer.
    always_comb begin
        commit    = (state_nx == BLANK) && (state != BLANK) && (d_nx == 2'd0);
        disp_nx   = disp;
        pend_nx   = pend;
        pend_v_nx = pend_v;
        if (commit && pend_v) begin
            disp_nx   = pend;
            pend_v_nx = 1'b0;
        end
        if (load_valid && load_ready) begin
            pend_nx   = load_data;
            pend_v_nx = 1'b1;
        end
    end

    always_comb begin
        case (d_nx)
            2'd0:    nib_sel = disp_nx[3:0];
            2'd1:    nib_sel = disp_nx[7:4];
            2'd2:    nib_sel = disp_nx[11:8];
            default: nib_sel = disp_nx[15:12];
        endcase
    end

`ifdef SEG_LZB_EN
    logic lz;
    always_comb begin
        case (d_nx)
            2'd1:    lz = (disp_nx[15:4] == 12'd0);
            2'd2:    lz = (disp_nx[15:8] == 8'd0);
            2'd3:    lz = (disp_nx[15:12] == 4'd0);
            default: lz = 1'b0;
        endcase
    end
`endif

    // Outputs are decoded from next-state values so the registered outputs track the state.
    always_comb begin
        nibble_nx     = '0;
        blank_nx      = 1'b1;
        digit_sel_nx  = '0;
        frame_done_nx = 1'b0;
        if (state_nx == ACTIVE) begin
            nibble_nx     = nib_sel;
            blank_nx      = 1'b0;
            digit_sel_nx  = 4'b0001 << d_nx;
            frame_done_nx = (d_nx == 2'd3) && (cnt_nx == TICK_LAST);
`ifdef SEG_LZB_EN
            if (lz) begin
                blank_nx     = 1'b1;
                digit_sel_nx = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nibble     <= '0;
            blank      <= 1'b1;
            digit_sel  <= '0;
            frame_done <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            nibble     <= nibble_nx;
            blank      <= blank_nx;
            digit_sel  <= digit_sel_nx;
            frame_done <= frame_done_nx;
            load_ready <= !pend_v_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues expected digit slots, a monitor checks them.
module tb_seg_scan_ctrl;

    localparam int TICK = 4;
    localparam int BLK  = 2;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [3:0]  nibble;
    logic        blank;
    logic [3:0]  digit_sel;
    logic        frame_done;

    seg_scan_ctrl #(
        .TICK_DIV  (TICK),
        .BLANK_CYC (BLK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .nibble     (nibble),
        .blank      (blank),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic [3:0] nib;
        int         len;
    } slot_t;

    slot_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    fd_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_slot(input logic [3:0] s, input logic [3:0] n, input int l);
        slot_t e;
        e.sel = s;
        e.nib = n;
        e.len = l;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [15:0] v);
        logic [15:0] sh;
        bit          show;
        for (int k = 0; k < 4; k++) begin
            sh   = v >> (4 * k);
            show = 1'b1;
`ifdef SEG_LZB_EN
            if (k > 0 && sh == 16'd0) show = 1'b0;
`endif
            if (show) push_slot(4'b0001 << k, sh[3:0], TICK);
        end
    endtask

    // Monitor: collect each lit digit slot and compare it with the head of the queue.
    int         cyc = 0;
    int         last_fd = -1;
    int         run_len = 0;
    logic [3:0] run_sel = '0;
    logic [3:0] run_nib = '0;
    logic       run_change = 1'b0;
    logic       prev_fd = 1'b0;
    slot_t      got;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n || !enable) last_fd = -1;
        chk("blank_vs_sel", 32'(blank), 32'(digit_sel == 4'b0000));
        if (digit_sel != 4'b0000) begin
            if (run_len == 0) begin
                run_sel    = digit_sel;
                run_nib    = nibble;
                run_change = 1'b0;
            end else if (digit_sel != run_sel || nibble != run_nib) begin
                run_change = 1'b1;
            end
            run_len++;
        end else if (run_len != 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_slot", 32'(run_sel), 32'd0);
            end else begin
                got = exp_q.pop_front();
                chk("slot_sel", 32'(run_sel), 32'(got.sel));
                chk("slot_nibble", 32'(run_nib), 32'(got.nib));
                chk("slot_len", 32'(run_len), 32'(got.len));
                chk("slot_stable", 32'(run_change), 32'd0);
                chk("slot_frame_done", 32'(prev_fd), 32'(run_sel == 4'b1000 && run_len == TICK));
            end
            run_len = 0;
        end
        if (frame_done) begin
            fd_cnt++;
`ifdef SEG_LZB_EN
            chk("fd_sel", 32'(digit_sel == 4'b1000 || digit_sel == 4'b0000), 32'd1);
`else
            chk("fd_sel", 32'(digit_sel), 32'b1000);
`endif
            if (last_fd >= 0) chk("frame_period", 32'(cyc - last_fd), 32'(4 * (TICK + BLK)));
            last_fd = cyc;
        end
        prev_fd = frame_done;
    end

    task automatic wait_sel(input logic [3:0] s, input logic [3:0] n);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (digit_sel == s && nibble == n) begin
                ok = 1'b1;
                break;
            end
        end
        chk("timeout_wait_sel", 32'(ok), 32'd1);
    endtask

    task automatic wait_q_empty();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("timeout_q_empty", 32'(ok), 32'd1);
    endtask

    task automatic wait_fd(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (fd_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk("timeout_fd", 32'(ok), 32'd1);
    endtask

    // Enable and count cycles until the first lit digit.
    task automatic startup(input string name);
        int n = 0;
        #1;
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            n++;
            if (digit_sel != 4'b0000) break;
        end
        chk(name, 32'(n), 32'(1 + BLK));
    endtask

    task automatic chk_reset_vals();
        chk("rst_digit_sel", 32'(digit_sel), 32'd0);
        chk("rst_nibble", 32'(nibble), 32'd0);
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
    endtask

    int stall;
    int fd0;

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals();
        rst_n = 1'b1;

        // Free-running scan of an all-zero value.
        push_frame(16'h0000);
        push_frame(16'h0000);
        startup("startup_latency");
        wait_q_empty();
        enable = 1'b0;

        // Load while idle; commit on enable.
        @(negedge clk); #1;
        chk("ready_idle", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = 16'h1234;
        @(negedge clk); #1;
        load_valid = 1'b0;
        chk("ready_after_accept", 32'(load_ready), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("ready_held_idle", 32'(load_ready), 32'd0);
        push_frame(16'h1234);
        push_frame(16'hABCD);
        push_slot(4'b0001, 4'h5, TICK);
        push_slot(4'b0010, 4'h5, TICK);
        push_slot(4'b0100, 4'h5, 1);
        push_slot(4'b0001, 4'h5, TICK);
        enable = 1'b1;
        @(negedge clk); #1;
        chk("ready_after_commit", 32'(load_ready), 32'd1);

        // Mid-frame update, then a second load that must stall until the next commit.
        wait_sel(4'b0010, 4'h3);
        load_valid = 1'b1;
        load_data  = 16'hABCD;
        @(negedge clk); #1;
        chk("ready_after_abcd", 32'(load_ready), 32'd0);
        load_data = 16'h5555;
        stall = 0;
        for (int i = 0; i < 100; i++) begin
            if (load_ready) break;
            stall++;
            @(negedge clk); #1;
        end
        chk("second_load_stall", 32'(stall), 32'd15);
        @(negedge clk); #1;
        load_valid = 1'b0;
        chk("ready_after_5555", 32'(load_ready), 32'd0);

        // Drop enable during digit2, then restart.
        wait_sel(4'b0100, 4'h5);
        enable = 1'b0;
        @(negedge clk); #1;
        chk("disable_sel", 32'(digit_sel), 32'd0);
        chk("disable_blank", 32'(blank), 32'd1);
        repeat (3) @(negedge clk);
        startup("restart_latency");

        // Pending value dropped by reset.
        load_valid = 1'b1;
        load_data  = 16'h9999;
        @(negedge clk); #1;
        load_valid = 1'b0;
        chk("ready_pend_9999", 32'(load_ready), 32'd0);
        wait_q_empty();
        rst_n  = 1'b0;
        enable = 1'b0;
        @(negedge clk); #1;
        chk_reset_vals();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        push_frame(16'h0000);
        startup("post_reset_latency");
        wait_q_empty();
        enable = 1'b0;

        // Value with leading zeros.
        @(negedge clk); #1;
        load_valid = 1'b1;
        load_data  = 16'h0050;
        @(negedge clk); #1;
        load_valid = 1'b0;
        push_frame(16'h0050);
        push_frame(16'h0050);
        fd0    = fd_cnt;
        enable = 1'b1;
        wait_fd(fd0 + 2);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
